// File: rtl/ipml_fifo_pkg.sv
// Shared helpers for the IPML block-RAM FIFO controllers: depth/level sizing
// functions and the reset image of the registered status flags.
package ipml_fifo_pkg;

  function automatic int depth_f(input int depth_width);
    return 1 << depth_width;
  endfunction

  // Level must reach DEPTH+1 in FWFT mode (RAM full plus the head word).
  function automatic int lvl_w_f(input int depth_width);
    return depth_width + 2;
  endfunction

  typedef struct packed {
    logic wfull;
    logic rempty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } flags_t;

  localparam flags_t FLAGS_RST = '{
    wfull:        1'b0,
    rempty:       1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/ipml_sync_fifo_ctrl_v2_if.sv
// User-side and RAM-side signal bundle of ipml_sync_fifo_ctrl_v2.
// master = surrounding wrapper/RAM, slave = the controller.
interface ipml_sync_fifo_ctrl_v2_if #(
  parameter int c_DEPTH_WIDTH = 9,
  parameter int c_DATA_WIDTH  = 32
);
  logic                      w_en;
  logic [c_DATA_WIDTH-1:0]   w_data;
  logic                      r_en;
  logic [c_DEPTH_WIDTH:0]    af_thresh;
  logic [c_DEPTH_WIDTH:0]    ae_thresh;
  logic                      clr_err;
  logic                      mem_wen;
  logic [c_DEPTH_WIDTH-1:0]  mem_waddr;
  logic [c_DATA_WIDTH-1:0]   mem_wdata;
  logic                      mem_ren;
  logic [c_DEPTH_WIDTH-1:0]  mem_raddr;
  logic [c_DATA_WIDTH-1:0]   mem_rdata;
  logic [c_DATA_WIDTH-1:0]   rd_data;
  logic                      rd_valid;
  logic                      wfull;
  logic                      rempty;
  logic                      almost_full;
  logic                      almost_empty;
  logic [c_DEPTH_WIDTH+1:0]  water_level;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output w_en, w_data, r_en, af_thresh, ae_thresh, clr_err, mem_rdata,
    input  mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr, rd_data, rd_valid,
           wfull, rempty, almost_full, almost_empty, water_level, overflow, underflow
  );

  modport slave (
    input  w_en, w_data, r_en, af_thresh, ae_thresh, clr_err, mem_rdata,
    output mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr, rd_data, rd_valid,
           wfull, rempty, almost_full, almost_empty, water_level, overflow, underflow
  );

endinterface

// File: rtl/ipml_fifo_ptr.sv
// Binary FIFO pointer with increment enable; wraps naturally modulo 2**c_PTR_WIDTH.
module ipml_fifo_ptr #(
  parameter int c_PTR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inc,
  output logic [c_PTR_WIDTH-1:0] ptr
);

  logic [c_PTR_WIDTH-1:0] ptr_q, ptr_d;

  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + c_PTR_WIDTH'(1);
  end

  // NOTE: state flops use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ipml_sync_fifo_ctrl_v2.sv
// Single-clock FIFO controller for an external SDP RAM with 1-cycle read latency.
// Define IPML_FIFO_FWFT_EN for first-word-fall-through; otherwise standard read mode.
module ipml_sync_fifo_ctrl_v2
  import ipml_fifo_pkg::*;
#(
  parameter int c_DEPTH_WIDTH = 9,
  parameter int c_DATA_WIDTH  = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  ipml_sync_fifo_ctrl_v2_if.slave fifo_if
);

  localparam int            AW      = c_DEPTH_WIDTH;
  localparam int            CW      = AW + 1;
  localparam int            LW      = lvl_w_f(AW);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth_f(AW));

  logic [CW-1:0]           wptr, rptr;
  logic [CW-1:0]           mem_cnt, mem_cnt_d;
  logic [LW-1:0]           level_q, level_d;
  flags_t                  flags_q, flags_d;
  logic                    wacc, ren;
  logic [c_DATA_WIDTH-1:0] wdata, rdata;

`ifdef IPML_FIFO_FWFT_EN
  logic head_valid_q, head_valid_d, pop;
`else
  logic rd_valid_q, rd_valid_d;
`endif

  // Pointers carry one extra bit, so their difference is the RAM occupancy 0..DEPTH.
  assign mem_cnt = wptr - rptr;

  always_comb begin
    flags_d = flags_q;
    // Enables are forced low while reset is held, even if w_en/r_en are active.
    wacc    = fifo_if.w_en & ~flags_q.wfull & rst_n;
`ifdef IPML_FIFO_FWFT_EN
    pop          = fifo_if.r_en & head_valid_q;
    ren          = (mem_cnt != '0) & (~head_valid_q | pop) & rst_n;
    head_valid_d = ren ? 1'b1 : (pop ? 1'b0 : head_valid_q);
`else
    ren        = fifo_if.r_en & ~flags_q.rempty & rst_n;
    rd_valid_d = ren;
`endif
    mem_cnt_d = mem_cnt + CW'(wacc) - CW'(ren);
`ifdef IPML_FIFO_FWFT_EN
    level_d        = LW'(mem_cnt_d) + LW'(head_valid_d);
    flags_d.rempty = ~head_valid_d;
`else
    level_d        = LW'(mem_cnt_d);
    flags_d.rempty = (mem_cnt_d == '0);
`endif
    flags_d.wfull        = (mem_cnt_d == DEPTH_C);
    flags_d.almost_full  = (level_d >= LW'(fifo_if.af_thresh));
    flags_d.almost_empty = (level_d <= LW'(fifo_if.ae_thresh));
    // Set has priority over clear when both happen in one cycle.
    flags_d.overflow     = (fifo_if.w_en & flags_q.wfull)
                         | (flags_q.overflow & ~fifo_if.clr_err);
    flags_d.underflow    = (fifo_if.r_en & flags_q.rempty)
                         | (flags_q.underflow & ~fifo_if.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q      <= '0;
      flags_q      <= FLAGS_RST;
`ifdef IPML_FIFO_FWFT_EN
      head_valid_q <= 1'b0;
`else
      rd_valid_q   <= 1'b0;
`endif
    end else begin
      level_q      <= level_d;
      flags_q      <= flags_d;
`ifdef IPML_FIFO_FWFT_EN
      head_valid_q <= head_valid_d;
`else
      rd_valid_q   <= rd_valid_d;
`endif
    end
  end

  ipml_fifo_ptr #(.c_PTR_WIDTH(CW)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wacc),
    .ptr   (wptr)
  );

  ipml_fifo_ptr #(.c_PTR_WIDTH(CW)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ren),
    .ptr   (rptr)
  );

  assign wdata                = fifo_if.w_data;
  assign rdata                = fifo_if.mem_rdata;
  assign fifo_if.mem_wen      = wacc;
  assign fifo_if.mem_waddr    = wptr[AW-1:0];
  assign fifo_if.mem_wdata    = wdata;
  assign fifo_if.mem_ren      = ren;
  assign fifo_if.mem_raddr    = rptr[AW-1:0];
  assign fifo_if.rd_data      = rdata;
`ifdef IPML_FIFO_FWFT_EN
  assign fifo_if.rd_valid     = ~flags_q.rempty;
`else
  assign fifo_if.rd_valid     = rd_valid_q;
`endif
  assign fifo_if.wfull        = flags_q.wfull;
  assign fifo_if.rempty       = flags_q.rempty;
  assign fifo_if.almost_full  = flags_q.almost_full;
  assign fifo_if.almost_empty = flags_q.almost_empty;
  assign fifo_if.water_level  = level_q;
  assign fifo_if.overflow     = flags_q.overflow;
  assign fifo_if.underflow    = flags_q.underflow;

endmodule

// File: tb/tb_ipml_sync_fifo_ctrl_v2.sv
// Scoreboard bench for ipml_sync_fifo_ctrl_v2 with a behavioural 1-cycle SDP RAM.
// Exercises FWFT-specific stimulus when IPML_FIFO_FWFT_EN is defined.
module tb_ipml_sync_fifo_ctrl_v2;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ipml_sync_fifo_ctrl_v2_if #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW)) fi ();

  ipml_sync_fifo_ctrl_v2 #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fifo_if (fi)
  );

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (fi.mem_wen) ram[fi.mem_waddr] <= fi.mem_wdata;
    if (fi.mem_ren) ram_q <= ram[fi.mem_raddr];
  end
  assign fi.mem_rdata = ram_q;

  logic [DW-1:0] sb [$];
  int n_pass  = 0;
  int n_total = 0;
`ifndef IPML_FIFO_FWFT_EN
  int lvl = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_in(input logic w, input logic [DW-1:0] wd, input logic r);
    fi.w_en   = w;
    fi.w_data = wd;
    fi.r_en   = r;
  endtask

  // Push expected read data for accepted writes, then advance one clock.
  task automatic tick();
`ifdef IPML_FIFO_FWFT_EN
    if (fi.w_en) sb.push_back(fi.w_data);
`else
    bit wa, ra;
    wa = fi.w_en && (lvl < DEPTH);
    ra = fi.r_en && (lvl > 0);
    if (wa) sb.push_back(fi.w_data);
    lvl = lvl + int'(wa) - int'(ra);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_wfull"},        32'(fi.wfull),        0);
    check({tag, "_rempty"},       32'(fi.rempty),       1);
    check({tag, "_almost_full"},  32'(fi.almost_full),  0);
    check({tag, "_almost_empty"}, 32'(fi.almost_empty), 1);
    check({tag, "_rd_valid"},     32'(fi.rd_valid),     0);
    check({tag, "_overflow"},     32'(fi.overflow),     0);
    check({tag, "_underflow"},    32'(fi.underflow),    0);
    check({tag, "_water_level"},  32'(fi.water_level),  0);
    check({tag, "_mem_wen"},      32'(fi.mem_wen),      0);
    check({tag, "_mem_ren"},      32'(fi.mem_ren),      0);
  endtask

  // Monitor: every word the DUT presents is compared against the queue head.
  initial begin
    forever begin
      @(negedge clk);
`ifdef IPML_FIFO_FWFT_EN
      if (rst_n && fi.rd_valid && fi.r_en) begin
`else
      if (fi.rd_valid) begin
`endif
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected_read: got 0x%0h with no word expected", fi.rd_data);
        end else begin
          check("sb_rd_data", fi.rd_data, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(1'b1, 32'h1111_1111, 1'b0);
    fi.clr_err   = 1'b0;
    fi.af_thresh = 10'd500;
    fi.ae_thresh = 10'd3;
    @(posedge clk);
    #1;
    reset_checks("rst_init");
    set_in(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Read while empty: dropped, underflow set; set beats simultaneous clear.
    set_in(1'b0, '0, 1'b1);
    #1;
    check("empty_rd_mem_ren", 32'(fi.mem_ren), 0);
    tick();
    check("underflow_set", 32'(fi.underflow), 1);
    fi.clr_err = 1'b1;
    tick();
    check("underflow_set_wins", 32'(fi.underflow), 1);
    set_in(1'b0, '0, 1'b0);
    tick();
    fi.clr_err = 1'b0;
    check("underflow_cleared", 32'(fi.underflow), 0);

`ifndef IPML_FIFO_FWFT_EN
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'hC000_0000 + i, 1'b0);
      if (i == 0) begin
        #1;
        check("first_wr_mem_wen", 32'(fi.mem_wen), 1);
        check("first_wr_mem_waddr", 32'(fi.mem_waddr), 0);
      end
      tick();
      if (i == 0)   check("rempty_after_first_wr", 32'(fi.rempty), 0);
      if (i == 2)   check("ae_at_3", 32'(fi.almost_empty), 1);
      if (i == 3)   check("ae_at_4", 32'(fi.almost_empty), 0);
      if (i == 498) check("af_at_499", 32'(fi.almost_full), 0);
      if (i == 499) check("af_at_500", 32'(fi.almost_full), 1);
      if (i == 510) begin
        check("wfull_at_511", 32'(fi.wfull), 0);
        check("level_at_511", 32'(fi.water_level), 511);
      end
    end
    check("wfull_at_512", 32'(fi.wfull), 1);
    check("level_at_512", 32'(fi.water_level), 512);

    set_in(1'b1, 32'hBAD0_0001, 1'b0);
    #1;
    check("full_wr_mem_wen", 32'(fi.mem_wen), 0);
    tick();
    check("overflow_set", 32'(fi.overflow), 1);
    check("level_after_drop", 32'(fi.water_level), 512);
    check("wptr_unchanged", 32'(fi.mem_waddr), 0);

    set_in(1'b0, '0, 1'b0);
    fi.clr_err = 1'b1;
    tick();
    fi.clr_err = 1'b0;
    check("overflow_cleared", 32'(fi.overflow), 0);

    // Full with simultaneous write and read: write dropped, read accepted.
    set_in(1'b1, 32'hBAD0_0002, 1'b1);
    tick();
    check("full_wr_rd_level", 32'(fi.water_level), 511);
    check("full_wr_rd_overflow", 32'(fi.overflow), 1);
    check("full_wr_rd_wfull", 32'(fi.wfull), 0);
    set_in(1'b0, '0, 1'b0);
    fi.clr_err = 1'b1;
    tick();
    fi.clr_err = 1'b0;

    for (int j = 0; j < DEPTH - 1; j++) begin
      set_in(1'b0, '0, 1'b1);
      tick();
      if (j == 10)  check("drain_af_at_500", 32'(fi.almost_full), 1);
      if (j == 11)  check("drain_af_at_499", 32'(fi.almost_full), 0);
      if (j == 506) check("drain_ae_at_4", 32'(fi.almost_empty), 0);
      if (j == 507) check("drain_ae_at_3", 32'(fi.almost_empty), 1);
    end
    check("drained_rempty", 32'(fi.rempty), 1);
    check("drained_level", 32'(fi.water_level), 0);
    set_in(1'b0, '0, 1'b0);
    tick();

    // Simultaneous write and read at level 10 keeps the level constant.
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h5000_0000 + i, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h6000_0000 + i, 1'b1);
      tick();
      check("wr_rd_level_10", 32'(fi.water_level), 10);
    end
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, '0, 1'b1);
      tick();
    end
    set_in(1'b0, '0, 1'b0);
    tick();
    check("wr_rd_drained", 32'(fi.rempty), 1);
`else
    // First word falls through two edges after it is driven.
    set_in(1'b1, 32'h0000_00A5, 1'b0);
    tick();
    check("fwft_rempty_edge1", 32'(fi.rempty), 1);
    set_in(1'b0, '0, 1'b0);
    tick();
    check("fwft_rd_data_edge2", fi.rd_data, 32'h0000_00A5);
    check("fwft_rempty_edge2", 32'(fi.rempty), 0);
    check("fwft_level_edge2", 32'(fi.water_level), 1);
    set_in(1'b0, '0, 1'b1);
    tick();
    check("fwft_empty_after_pop", 32'(fi.rempty), 1);

    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h0F00_0000 + i, 1'b0);
      tick();
    end
    set_in(1'b0, '0, 1'b0);
    tick();
    check("fwft_prefill_level", 32'(fi.water_level), 4);
    for (int i = 0; i < 600; i++) begin
      set_in(1'b1, 32'h1000_0000 + i, 1'b1);
      tick();
      check("fwft_no_bubble", 32'(fi.rd_valid), 1);
    end
    check("fwft_stream_level", 32'(fi.water_level), 4);
    set_in(1'b0, '0, 1'b1);
    for (int k = 0; k < 8 && !fi.rempty; k++) tick();
    check("fwft_stream_drained", 32'(fi.rempty), 1);
    set_in(1'b0, '0, 1'b0);
    tick();
`endif

    // Reset asserted at level 200 with a read request pending.
    for (int i = 0; i < 200; i++) begin
      set_in(1'b1, 32'h7000_0000 + i, 1'b0);
      tick();
    end
    set_in(1'b0, '0, 1'b0);
    tick();
    check("level_200", 32'(fi.water_level), 200);
    set_in(1'b0, '0, 1'b1);
    #1;
    check("pending_rd_mem_ren", 32'(fi.mem_ren), 1);
    #1;
    rst_n = 1'b0;
    #1;
    reset_checks("rst_mid");
    sb.delete();
`ifndef IPML_FIFO_FWFT_EN
    lvl = 0;
`endif
    set_in(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_rd_valid", 32'(fi.rd_valid), 0);
    check("post_rst_rempty", 32'(fi.rempty), 1);
    check("post_rst_level", 32'(fi.water_level), 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
